// File: rtl/dff_pipeline_if.sv
// Handshake bundle for dff_pipeline: input side, output side, flush and occupancy.
// The master modport drives data in and consumes it; the slave modport is the pipeline itself.
interface dff_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/dff_pipeline.sv
// DEPTH-stage WIDTH-bit register pipeline with per-stage valids, valid/ready on both ends,
// synchronous flush and a registered occupancy count. ELASTIC selects bubble collapsing.
module dff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ELASTIC   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  dff_pipeline_if.slave bus_io
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic [DEPTH-1:0] rdy;
  logic             in_ready_int;
  logic             in_fire;
  logic             out_fire;

  // rdy[k] means stage k may load from its upstream neighbour this cycle.
  always_comb begin
    rdy = '0;
    if (ELASTIC) begin
      rdy[DEPTH-1] = ~valid_q[DEPTH-1] | bus_io.out_ready;
      for (int k = DEPTH - 2; k >= 0; k--) begin
        rdy[k] = ~valid_q[k] | rdy[k+1];
      end
    end else begin
      rdy = {DEPTH{bus_io.out_ready | ~valid_q[DEPTH-1]}};
    end
  end

  assign in_ready_int = rdy[0] & ~bus_io.flush & ~rst;
  assign in_fire      = bus_io.in_valid & in_ready_int;
  assign out_fire     = valid_q[DEPTH-1] & bus_io.out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid = in_fire;
      assign src_data  = bus_io.in_data;
    end else begin : g_body
      assign src_valid = valid_q[gi-1];
      assign src_data  = data_q[gi-1];
    end

    // Data only moves with a valid item, so a stalled or flushed stage keeps its contents.
    assign valid_d[gi] = bus_io.flush ? 1'b0 : (rdy[gi] ? src_valid : valid_q[gi]);
    assign data_d[gi]  = (rdy[gi] & src_valid & ~bus_io.flush) ? src_data : data_q[gi];
  end

  always_comb begin
    occ_d = occ_q;
    if (bus_io.flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
    end
  end

  assign bus_io.in_ready  = in_ready_int;
  assign bus_io.out_valid = valid_q[DEPTH-1];
  assign bus_io.out_data  = data_q[DEPTH-1];
  assign bus_io.occupancy = occ_q;
endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: elastic and lockstep DEPTH=4 instances plus a DEPTH=1 instance,
// directed checks in the stimulus thread and a queue scoreboard in a negedge monitor.
module tb_dff_pipeline;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q [3][$];

  dff_pipeline_if #(.WIDTH(8), .DEPTH(4)) ifa ();
  dff_pipeline_if #(.WIDTH(8), .DEPTH(4)) ifb ();
  dff_pipeline_if #(.WIDTH(8), .DEPTH(1)) ifc ();

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .ELASTIC(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus_io(ifa)
  );
  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .ELASTIC(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus_io(ifb)
  );
  dff_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .ELASTIC(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus_io(ifc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Occupancy must equal the number of accepted-but-not-emitted items held in the queue.
  task automatic mon(input int id, input logic iv, input logic ir, input logic ov,
                     input logic ordy, input logic [7:0] idat, input logic [7:0] odat,
                     input int occ);
    logic [7:0] e;
    chk($sformatf("occ%0d", id), 32'(occ), 32'(exp_q[id].size()));
    if (ov && ordy) begin
      if (exp_q[id].size() == 0) begin
        tests++;
        failed++;
        $display("FAIL out%0d: actual=%0h required=no output at %0t", id, odat, $time);
      end else begin
        e = exp_q[id].pop_front();
        chk($sformatf("out%0d", id), 32'(odat), 32'(e));
      end
    end
    if (iv && ir) exp_q[id].push_back(idat);
  endtask

  always @(negedge clk) begin
    mon(0, ifa.in_valid, ifa.in_ready, ifa.out_valid, ifa.out_ready, ifa.in_data,
        ifa.out_data, int'(ifa.occupancy));
    mon(1, ifb.in_valid, ifb.in_ready, ifb.out_valid, ifb.out_ready, ifb.in_data,
        ifb.out_data, int'(ifb.occupancy));
    mon(2, ifc.in_valid, ifc.in_ready, ifc.out_valid, ifc.out_ready, ifc.in_data,
        ifc.out_data, int'(ifc.occupancy));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      ifa.in_valid  = 1'b0;
      ifa.out_ready = 1'b1;
      ifb.in_valid  = 1'b0;
      ifb.out_ready = 1'b1;
      smp();
    end
  endtask

  initial begin
    int  c_cnt;
    logic erdy;
    logic v;

    rst = 1'b1;
    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.out_ready = 1'b0;
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.out_ready = 1'b0;
    ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = 8'h00; ifc.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_out_data", 32'(ifa.out_data), 32'h5A);
    chk("rst_occ", 32'(ifa.occupancy), 0);
    chk("rst_in_ready", 32'(ifa.in_ready), 0);
    #10;
    rst = 1'b0;

    // Streaming with no back-pressure: 4-cycle latency, then one item per cycle.
    for (int i = 0; i < 20; i++) begin
      cyc();
      ifa.in_valid  = (i < 16);
      ifa.in_data   = 8'(i + 1);
      ifa.out_ready = 1'b1;
      smp();
      chk("t1_in_ready", 32'(ifa.in_ready), 1);
      chk("t1_out_valid", 32'(ifa.out_valid), 32'(i >= 4));
      if (i >= 4) chk("t1_out_data", 32'(ifa.out_data), 32'(i - 3));
      if (i >= 4 && i <= 16) chk("t1_occ", 32'(ifa.occupancy), 4);
    end

    // Back-pressure: four items fill the pipe, the fifth waits for one output slot.
    for (int i = 0; i < 4; i++) begin
      cyc();
      ifa.in_valid  = 1'b1;
      ifa.in_data   = 8'(8'hA0 + i);
      ifa.out_ready = 1'b0;
      smp();
      chk("t2_accept", 32'(ifa.in_ready), 1);
    end
    cyc();
    ifa.in_data = 8'hA4;
    smp();
    chk("t2_full_in_ready", 32'(ifa.in_ready), 0);
    chk("t2_full_occ", 32'(ifa.occupancy), 4);
    chk("t2_full_out_valid", 32'(ifa.out_valid), 1);
    chk("t2_full_out_data", 32'(ifa.out_data), 32'hA0);
    cyc();
    ifa.out_ready = 1'b1;
    smp();
    chk("t2_release_in_ready", 32'(ifa.in_ready), 1);
    chk("t2_release_out_data", 32'(ifa.out_data), 32'hA0);
    cyc();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b0;
    smp();
    chk("t2_after_occ", 32'(ifa.occupancy), 4);
    chk("t2_after_out_data", 32'(ifa.out_data), 32'hA1);
    drain(6);

    // Elastic collapses the bubble; lockstep carries it and stalls the input.
    for (int i = 0; i < 7; i++) begin
      cyc();
      v = (i == 0) || (i == 3);
      ifa.in_valid = v; ifa.in_data = (i == 0) ? 8'h11 : 8'h22; ifa.out_ready = 1'b0;
      ifb.in_valid = v; ifb.in_data = (i == 0) ? 8'h11 : 8'h22; ifb.out_ready = 1'b0;
      smp();
      if (i == 3) begin
        chk("t3_a_in_ready_push", 32'(ifa.in_ready), 1);
        chk("t3_b_in_ready_push", 32'(ifb.in_ready), 1);
      end
      if (i >= 4) begin
        chk("t3_b_in_ready", 32'(ifb.in_ready), 0);
        chk("t3_b_stages", 32'(dut_b.valid_q), 32'b1001);
        chk("t3_b_occ", 32'(ifb.occupancy), 2);
      end
    end
    chk("t3_a_stages", 32'(dut_a.valid_q), 32'b1100);
    chk("t3_a_occ", 32'(ifa.occupancy), 2);
    chk("t3_a_in_ready", 32'(ifa.in_ready), 1);
    chk("t3_a_out_data", 32'(ifa.out_data), 32'h11);
    drain(6);

    // Flush with three items in flight and an input waiting.
    for (int i = 0; i < 3; i++) begin
      cyc();
      ifa.in_valid  = 1'b1;
      ifa.in_data   = 8'(8'hB1 + i);
      ifa.out_ready = 1'b0;
      smp();
    end
    cyc();
    ifa.flush   = 1'b1;
    ifa.in_data = 8'hB4;
    smp();
    chk("t4_flush_in_ready", 32'(ifa.in_ready), 0);
    chk("t4_before_occ", 32'(ifa.occupancy), 3);
    cyc();
    ifa.flush    = 1'b0;
    ifa.in_valid = 1'b0;
    exp_q[0].delete();
    smp();
    chk("t4_out_valid", 32'(ifa.out_valid), 0);
    chk("t4_occ", 32'(ifa.occupancy), 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      ifa.out_ready = 1'b1;
      smp();
      chk("t4_no_emit", 32'(ifa.out_valid), 0);
    end

    // Asynchronous reset between edges while streaming.
    for (int i = 0; i < 6; i++) begin
      cyc();
      ifa.in_valid  = 1'b1;
      ifa.in_data   = 8'(8'hC0 + i);
      ifa.out_ready = 1'b1;
      smp();
    end
    cyc();
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    #1;
    chk("t5_out_valid", 32'(ifa.out_valid), 0);
    chk("t5_out_data", 32'(ifa.out_data), 32'h5A);
    chk("t5_occ", 32'(ifa.occupancy), 0);
    chk("t5_in_ready", 32'(ifa.in_ready), 0);
    smp();
    cyc();
    ifa.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      ifa.in_valid  = (i < 8);
      ifa.in_data   = 8'(8'hD0 + i);
      ifa.out_ready = 1'b1;
      smp();
      chk("t5_restart_valid", 32'(ifa.out_valid), 32'(i >= 4));
      if (i >= 4) chk("t5_restart_data", 32'(ifa.out_data), 32'(8'hD0 + i - 4));
    end

    // Single-stage random handshake against a one-slot count model.
    c_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.out_ready = 1'($urandom_range(0, 1));
      ifc.in_data   = 8'($urandom);
      smp();
      erdy = (c_cnt == 0) || ifc.out_ready;
      chk("t6_in_ready", 32'(ifc.in_ready), 32'(erdy));
      chk("t6_out_valid", 32'(ifc.out_valid), 32'(c_cnt == 1));
      c_cnt = c_cnt - ((c_cnt == 1 && ifc.out_ready) ? 1 : 0)
                    + ((ifc.in_valid && erdy) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      smp();
    end

    for (int k = 0; k < 3; k++) chk($sformatf("end_empty%0d", k), 32'(exp_q[k].size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
